// File: rtl/tiamc1_nvram_upload.sv
// Upload-side responder for the HPS ioctl channel: pauses the core CPU and
// returns bytes from a window of core work RAM for NVRAM / high-score saves.
module tiamc1_nvram_upload #(
  parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
  parameter logic [15:0] BASE_ADDR    = 16'hE000,
  parameter int unsigned SIZE         = 2048
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        cpu_pause,
  input  logic        pause_ack,
  output logic [15:0] ram_addr,
  output logic        ram_rd,
  input  logic        ram_ack,
  input  logic [7:0]  ram_dout,
  output logic        busy
);

  localparam logic [24:0] SIZE_LIM = 25'(SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_READY,
    S_READ,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic        upload_q;
  logic        pend_q, pend_d;
  logic [24:0] pend_addr_q, pend_addr_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [7:0]  din_q, din_d;

  logic        upload_rise;
  logic        upload_fall;
  logic        accept;
  logic        req_valid;
  logic [24:0] req_addr;
  logic        req_in_range;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      upload_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      ram_addr_q  <= BASE_ADDR;
      din_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      upload_q    <= ioctl_upload;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      ram_addr_q  <= ram_addr_d;
      din_q       <= din_d;
    end
  end

  // A fresh strobe in READY is serviced in its own cycle, so the pending
  // slot and the live strobe are merged into one effective request.
  always_comb begin
    upload_rise  = ioctl_upload & ~upload_q;
    upload_fall  = ~ioctl_upload & upload_q;
    accept       = ((state_q == S_PAUSE) || (state_q == S_READY)) && ioctl_rd && !pend_q;
    req_valid    = pend_q || accept;
    req_addr     = pend_q ? pend_addr_q : ioctl_addr;
    req_in_range = req_addr < SIZE_LIM;
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    ram_addr_d  = ram_addr_q;
    din_d       = din_q;

    unique case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (upload_rise && (ioctl_index == UPLOAD_INDEX)) begin
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (upload_fall) begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (accept) begin
            pend_d      = 1'b1;
            pend_addr_d = ioctl_addr;
            if (req_in_range) begin
              ram_addr_d = BASE_ADDR + ioctl_addr[15:0];
            end
          end
          if (pause_ack) begin
            state_d = S_READY;
          end
        end
      end

      S_READY: begin
        if (upload_fall) begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else if (req_valid) begin
          if (!req_in_range) begin
            din_d  = 8'hFF;
            pend_d = 1'b0;
          end else begin
            pend_d      = 1'b1;
            pend_addr_d = req_addr;
            ram_addr_d  = BASE_ADDR + req_addr[15:0];
            if (pause_ack) begin
              state_d = S_READ;
            end
          end
        end
      end

      S_READ: begin
        if (ram_ack) begin
          pend_d  = 1'b0;
          state_d = upload_fall ? S_IDLE : S_READY;
          if (!upload_fall) begin
            din_d = ram_dout;
          end
        end else if (upload_fall) begin
          pend_d  = 1'b0;
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        pend_d = 1'b0;
        if (ram_ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // The RAM request is gated by reset so it drops in the reset cycle itself.
  always_comb begin
    busy       = (state_q != S_IDLE);
    cpu_pause  = busy;
    ram_rd     = ((state_q == S_READ) || (state_q == S_DRAIN)) && !reset;
    ioctl_wait = busy && !reset && (ioctl_rd || pend_q);
    ram_addr   = ram_addr_q;
    ioctl_din  = din_q;
  end

endmodule

// File: tb/tb_tiamc1_nvram_upload.sv
// Directed bench for tiamc1_nvram_upload with a behavioural CPU-pause
// handshake and a RAM whose byte at each address equals addr[7:0].
module tb_tiamc1_nvram_upload;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        cpu_pause;
  logic        pause_ack = 1'b0;
  logic [15:0] ram_addr;
  logic        ram_rd;
  logic        ram_ack = 1'b0;
  logic [7:0]  ram_dout = 8'hA5;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int pause_delay = 1;
  int ram_delay = 0;
  int pcnt = 0;
  int rcnt = 0;
  int ram_rd_rises = 0;
  logic ram_rd_prev = 1'b0;

  tiamc1_nvram_upload dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .cpu_pause    (cpu_pause),
    .pause_ack    (pause_ack),
    .ram_addr     (ram_addr),
    .ram_rd       (ram_rd),
    .ram_ack      (ram_ack),
    .ram_dout     (ram_dout),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Responders update on the falling edge; the checks run 1 ns later.
  always @(negedge clk_sys) begin
    if (cpu_pause) pcnt = pcnt + 1;
    else pcnt = 0;
    pause_ack = cpu_pause && (pcnt > pause_delay);
    if (ram_rd) rcnt = rcnt + 1;
    else rcnt = 0;
    ram_ack = ram_rd && (rcnt == ram_delay + 1);
    ram_dout = ram_ack ? ram_addr[7:0] : 8'hA5;
    if (ram_rd && !ram_rd_prev) ram_rd_rises = ram_rd_rises + 1;
    ram_rd_prev = ram_rd;
  end

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic start_session(input logic [7:0] idx);
    bit acked;
    acked = 0;
    ioctl_index = idx;
    ioctl_upload = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (pause_ack) begin
        acked = 1;
        break;
      end
    end
    n_checks++;
    if (!acked) begin
      n_fail++;
      $display("[TB] FAIL session_start: pause_ack got %0b, wanted 1", acked);
    end
    tick();
  endtask

  task automatic end_session();
    ioctl_upload = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if (ioctl_din !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_din: got %h wanted 00", ioctl_din); end
    n_checks++;
    if ({ioctl_wait, cpu_pause, ram_rd, busy} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: wait/pause/rd/busy got %b wanted 0000", {ioctl_wait, cpu_pause, ram_rd, busy});
    end
    n_checks++;
    if (ram_addr !== 16'hE000) begin n_fail++; $display("[TB] FAIL reset_ram_addr: got %h wanted E000", ram_addr); end
  endtask

  task automatic test_sequential();
    ioctl_index = 8'd4;
    ioctl_upload = 1'b1;
    tick();
    n_checks++;
    if (cpu_pause !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL upload_rise_pause: pause/busy got %b%b wanted 11", cpu_pause, busy);
    end
    tick();
    tick();
    for (int off = 0; off < 2048; off++) begin
      ioctl_rd = 1'b1;
      ioctl_addr = 25'(off);
      #1;
      n_checks++;
      if (ioctl_wait !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_wait_strobe off=%0d: got %b wanted 1", off, ioctl_wait); end
      tick();
      ioctl_rd = 1'b0;
      #1;
      n_checks++;
      if (ioctl_wait !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_wait_pending off=%0d: got %b wanted 1", off, ioctl_wait); end
      tick();
      n_checks++;
      if (ioctl_wait !== 1'b0 || ioctl_din !== 8'(off)) begin
        n_fail++;
        $display("[TB] FAIL seq_data off=%0d: wait=%b din=%h wanted wait=0 din=%h", off, ioctl_wait, ioctl_din, 8'(off));
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [24:0] offs [2];
    int rises_before;
    offs[0] = 25'd2048;
    offs[1] = 25'h1FFFFFF;
    rises_before = ram_rd_rises;
    for (int i = 0; i < 2; i++) begin
      ioctl_rd = 1'b1;
      ioctl_addr = offs[i];
      #1;
      n_checks++;
      if (ioctl_wait !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_wait_strobe %h: got %b wanted 1", offs[i], ioctl_wait); end
      tick();
      n_checks++;
      if (ioctl_din !== 8'hFF || ram_rd !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL oor_data %h: din=%h ram_rd=%b wanted FF 0", offs[i], ioctl_din, ram_rd);
      end
      ioctl_rd = 1'b0;
      #1;
      n_checks++;
      if (ioctl_wait !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_wait_after %h: got %b wanted 0", offs[i], ioctl_wait); end
      tick();
    end
    n_checks++;
    if (ram_rd_rises !== rises_before) begin
      n_fail++;
      $display("[TB] FAIL oor_no_ram: ram_rd rises got %0d wanted %0d", ram_rd_rises, rises_before);
    end
  endtask

  task automatic test_pause_delay();
    bit acked;
    bit done;
    pause_delay = 20;
    ioctl_index = 8'd4;
    ioctl_upload = 1'b1;
    tick();
    n_checks++;
    if (cpu_pause !== 1'b1) begin n_fail++; $display("[TB] FAIL pd_pause: got %b wanted 1", cpu_pause); end
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd5;
    tick();
    ioctl_addr = 25'd7;
    tick();
    ioctl_rd = 1'b0;
    acked = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (pause_ack) begin
        acked = 1;
        break;
      end
      n_checks++;
      if (ioctl_wait !== 1'b1) begin n_fail++; $display("[TB] FAIL pd_wait_held: got %b wanted 1", ioctl_wait); end
      tick();
    end
    n_checks++;
    if (!acked) begin n_fail++; $display("[TB] FAIL pd_ack_timeout: pause_ack got 0 wanted 1"); end
    tick();
    n_checks++;
    if (ram_addr !== 16'hE005) begin n_fail++; $display("[TB] FAIL pd_ram_addr: got %h wanted E005", ram_addr); end
    done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ioctl_wait === 1'b0) begin
        done = 1;
        break;
      end
    end
    n_checks++;
    if (!done || ioctl_din !== 8'h05) begin
      n_fail++;
      $display("[TB] FAIL pd_data: done=%0b din=%h wanted 1 05", done, ioctl_din);
    end
    pause_delay = 1;
  endtask

  task automatic test_drain();
    bit acked;
    ram_delay = 7;
    ioctl_rd = 1'b1;
    ioctl_addr = 25'd9;
    tick();
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    #1;
    acked = 0;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (ram_rd !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_rd_held: got %b wanted 1", ram_rd); end
      if (ram_ack) begin
        acked = 1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!acked) begin n_fail++; $display("[TB] FAIL drain_ack_timeout: ram_ack got 0 wanted 1"); end
    tick();
    n_checks++;
    if ({cpu_pause, ram_rd, busy} !== 3'b000 || ioctl_din !== 8'h05) begin
      n_fail++;
      $display("[TB] FAIL drain_idle: pause/rd/busy=%b din=%h wanted 000 05", {cpu_pause, ram_rd, busy}, ioctl_din);
    end
    ram_delay = 0;
    tick();
  endtask

  task automatic test_wrong_index();
    ioctl_index = 8'd0;
    ioctl_upload = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ioctl_rd = 1'b1;
      ioctl_addr = 25'(i * 3);
      tick();
      ioctl_rd = 1'b0;
      tick();
      n_checks++;
      if ({cpu_pause, ram_rd, busy, ioctl_wait} !== 4'b0000 || ioctl_din !== 8'h05) begin
        n_fail++;
        $display("[TB] FAIL wrong_index: pause/rd/busy/wait=%b din=%h wanted 0000 05", {cpu_pause, ram_rd, busy, ioctl_wait}, ioctl_din);
      end
    end
    end_session();
  endtask

  task automatic test_reset_in_read();
    start_session(8'd4);
    ram_delay = 30;
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h10;
    tick();
    ioctl_rd = 1'b0;
    #1;
    n_checks++;
    if (ram_rd !== 1'b1) begin n_fail++; $display("[TB] FAIL rr_in_read: ram_rd got %b wanted 1", ram_rd); end
    reset = 1'b1;
    ioctl_upload = 1'b0;
    #1;
    n_checks++;
    if (ram_rd !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_withdraw: ram_rd got %b wanted 0", ram_rd); end
    tick();
    n_checks++;
    if (ioctl_din !== 8'h00 || ram_addr !== 16'hE000 || {ioctl_wait, cpu_pause, ram_rd, busy} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL rr_outputs: din=%h addr=%h wait/pause/rd/busy=%b wanted 00 E000 0000",
               ioctl_din, ram_addr, {ioctl_wait, cpu_pause, ram_rd, busy});
    end
    reset = 1'b0;
    ram_delay = 0;
    tick();
    start_session(8'd4);
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h33;
    tick();
    ioctl_rd = 1'b0;
    tick();
    n_checks++;
    if (ioctl_wait !== 1'b0 || ioctl_din !== 8'h33) begin
      n_fail++;
      $display("[TB] FAIL rr_after: wait=%b din=%h wanted 0 33", ioctl_wait, ioctl_din);
    end
    end_session();
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_sequential();
    test_out_of_range();
    end_session();
    n_checks++;
    if (cpu_pause !== 1'b0) begin n_fail++; $display("[TB] FAIL end_session_pause: got %b wanted 0", cpu_pause); end
    test_pause_delay();
    test_drain();
    test_wrong_index();
    test_reset_in_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tiamc1_nvram_upload.md
# tiamc1_nvram_upload

Upload-side responder for the HPS ioctl channel. It services host read requests during an upload session by pausing the game CPU, fetching bytes from a window of core work RAM over a request/acknowledge port, and returning them on `ioctl_din` with `ioctl_wait` flow control. It sits between `hps_io` and the `tiamc1` core. It is the read-back counterpart of the ROM download path, and is used for high-score and NVRAM saves.

## Interface
Parameters:
- `UPLOAD_INDEX`, default 8'd4: `ioctl_index` value that selects this block.
- `BASE_ADDR`, default 16'hE000: first core RAM address of the window.
- `SIZE`, default 16'd2048: window length in bytes (1..65536−BASE_ADDR).

Ports:
- `clk_sys` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset.
- `ioctl_upload` in 1: upload session active (level).
- `ioctl_index` in 8: session selector, sampled at `ioctl_upload` rise.
- `ioctl_rd` in 1: one-cycle byte read strobe.
- `ioctl_addr` in 25: byte offset within the window, valid with `ioctl_rd`.
- `ioctl_din` out 8: returned byte; holds its value until the next completion.
- `ioctl_wait` out 1: host must not sample `ioctl_din` while this is high.
- `cpu_pause` out 1: request that the core CPU halt.
- `pause_ack` in 1: CPU is halted and the RAM port is free.
- `ram_addr` out 16: RAM read address.
- `ram_rd` out 1: RAM read request; held until acknowledged.
- `ram_ack` in 1: one-cycle acknowledge; `ram_dout` is valid in the same cycle.
- `ram_dout` in 8: RAM read data.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, PAUSE, READY, READ, DRAIN.
- IDLE → PAUSE on a rising edge of `ioctl_upload` when `ioctl_index == UPLOAD_INDEX`. Sessions with any other index are ignored; the block stays in IDLE and its outputs stay at their idle values.
- PAUSE: `cpu_pause` = 1. → READY when `pause_ack` = 1.
- `ioctl_rd` in PAUSE or READY latches `ioctl_addr` into a one-entry pending slot and sets a pending flag. The pending request is serviced on entry to READY.
- READY with a pending request whose offset is below SIZE: `ram_addr` = BASE_ADDR + offset[15:0], `ram_rd` = 1, → READ.
- READY with a pending request whose offset is ≥ SIZE (the full 25 bits are compared): `ioctl_din` = 8'hFF, pending cleared, no RAM access, stay in READY.
- READ: `ram_rd` stays high. On `ram_ack`: `ioctl_din` ← `ram_dout`, pending cleared, `ram_rd` dropped, → READY.
- `ioctl_wait` = `ioctl_rd` OR pending. It is combinational on `ioctl_rd` so that the host sees wait in the strobe cycle.
- `ioctl_rd` while pending is already set is a protocol violation. The strobe is ignored and the original request completes.
- Falling edge of `ioctl_upload`:
  - From PAUSE or READY: → IDLE and the pending request is dropped.
  - From READ: → DRAIN. `ram_rd` stays high until `ram_ack`, the fetched data is discarded, then → IDLE.
- `cpu_pause` = 1 in PAUSE, READY, READ and DRAIN; 0 in IDLE.
- If `pause_ack` falls while in READY or READ, no new RAM request is issued until it returns. An in-flight request still completes.
- Reset from any state forces IDLE on the next edge. `ram_rd` is withdrawn immediately; the RAM side must tolerate a withdrawn request during reset.

## Timing
- Reset values: `ioctl_din` = 8'h00; `ioctl_wait`, `cpu_pause`, `ram_rd`, `busy` = 0; `ram_addr` = BASE_ADDR.
- `ioctl_rd` at cycle T in READY:
  - `ram_rd` and `ram_addr` are registered high at T+1.
  - If `ram_ack` arrives at T+1+k, `ioctl_din` is valid and `ioctl_wait` = 0 at T+2+k.
  - Minimum read latency is 2 cycles.
- Out-of-range read at T: `ioctl_din` = FF and `ioctl_wait` = 0 at T+1.
- `ioctl_upload` rise at T: `cpu_pause` = 1 at T+1. `pause_ack` at A gives READY at A+1.
- `ioctl_upload` fall at T in READY: `cpu_pause` = 0 at T+1.

## Test plan
- Window preloaded with byte = addr[7:0]; `pause_ack` one cycle after `cpu_pause`; `ram_ack` 0 cycles after `ram_rd` → read offsets 0..2047 in order; `ioctl_din` = offset[7:0] each time, wait low 2 cycles after every strobe.
- Offsets 2048 and 25'h1FFFFFF → `ioctl_din` = 8'hFF, one-cycle wait, `ram_rd` never asserted.
- `ioctl_rd` for offset 5 issued while `pause_ack` is delayed 20 cycles → `ioctl_wait` stays high throughout; `ram_addr` = 16'hE005 the cycle after the ack; correct byte returned.
- `ioctl_upload` dropped during READ with `ram_ack` delayed 7 cycles → `ram_rd` is held until the ack, `ioctl_din` is unchanged, then IDLE and `cpu_pause` = 0 the cycle after.
- Session with `ioctl_index` = 0 and reads issued → `cpu_pause`, `ram_rd` and `busy` stay 0; `ioctl_din` is unchanged.
- Reset asserted in READ → all outputs at reset values the next cycle; a following valid session works normally.
